// File: rtl/swu_mmv_packer.sv
// swu_mmv_packer: re-packs a pixel-serial stream into MMV_IN-pixel beats via two
// ping-pong banks. Define SWU_MMV_PACK_TLAST_EN to add m_axis_tlast (end of frame).
module swu_mmv_packer #(
    parameter int MMV_IN       = 3,
    parameter int SIMD         = 1,
    parameter int IP_PRECISION = 8,
    parameter int IFMChannels  = 2,
    parameter int IFMWidth     = 6,
    parameter int IFMHeight    = 6
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [SIMD*IP_PRECISION-1:0]        s_axis_tdata,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    output logic [MMV_IN*SIMD*IP_PRECISION-1:0] m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready
`ifdef SWU_MMV_PACK_TLAST_EN
    ,
    output logic                                m_axis_tlast
`endif
);

    localparam int WW    = SIMD * IP_PRECISION;
    localparam int CF    = IFMChannels / SIMD;
    localparam int GPR   = (IFMWidth + MMV_IN - 1) / MMV_IN;
    localparam int TAIL  = IFMWidth - (GPR - 1) * MMV_IN;
    localparam int DEPTH = MMV_IN * CF;
    localparam int FW    = (CF > 1) ? $clog2(CF) : 1;
    localparam int LW    = $clog2(MMV_IN + 1);
    localparam int GW    = (GPR > 1) ? $clog2(GPR) : 1;
    localparam int RW    = (IFMHeight > 1) ? $clog2(IFMHeight) : 1;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [FW-1:0] FOLD_LAST = FW'(CF - 1);
    localparam logic [GW-1:0] GRP_LAST  = GW'(GPR - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IFMHeight - 1);
    localparam logic [LW-1:0] SZ_FULL   = LW'(MMV_IN);
    localparam logic [LW-1:0] SZ_TAIL   = LW'(TAIL);

    logic [WW-1:0]        r_bank [2][DEPTH];
    logic [1:0]           r_full;
    logic [1:0][LW-1:0]   r_size;
    logic                 r_wb;
    logic                 r_rb;
    logic [FW-1:0]        r_wr_fold;
    logic [LW-1:0]        r_wr_lane;
    logic [GW-1:0]        r_wr_grp;
    logic [RW-1:0]        r_wr_row;
    logic [FW-1:0]        r_rd_fold;

    logic                 w_wr_en;
    logic                 w_rd_en;
    logic                 w_fold_end;
    logic                 w_grp_done;
    logic                 w_rd_done;
    logic                 w_grp_last;
    logic [LW-1:0]        w_grp_size;
    logic [IW-1:0]        w_wr_idx;

    assign s_axis_tready = !r_full[r_wb];
    assign m_axis_tvalid = r_full[r_rb];
    assign w_wr_en       = s_axis_tvalid && s_axis_tready;
    assign w_rd_en       = m_axis_tvalid && m_axis_tready;
    assign w_grp_last    = (r_wr_grp == GRP_LAST);
    assign w_grp_size    = w_grp_last ? SZ_TAIL : SZ_FULL;
    assign w_fold_end    = (r_wr_fold == FOLD_LAST);
    assign w_grp_done    = w_wr_en && w_fold_end
                           && (r_wr_lane == w_grp_size - LW'(1));
    assign w_rd_done     = w_rd_en && (r_rd_fold == FOLD_LAST);
    assign w_wr_idx      = IW'(int'(r_wr_lane) * CF + int'(r_wr_fold));

    // Bank contents need no reset: the FULL flags gate every read.
    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            r_bank[r_wb][w_wr_idx] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_full    <= '0;
            r_size    <= '0;
            r_wb      <= 1'b0;
            r_rb      <= 1'b0;
            r_wr_fold <= '0;
            r_wr_lane <= '0;
            r_wr_grp  <= '0;
            r_wr_row  <= '0;
            r_rd_fold <= '0;
        end else begin
            // Fill and drain always target different banks when both fire.
            if (w_rd_done) begin
                r_full[r_rb] <= 1'b0;
                r_rb         <= !r_rb;
            end
            if (w_grp_done) begin
                r_full[r_wb] <= 1'b1;
                r_size[r_wb] <= w_grp_size;
                r_wb         <= !r_wb;
            end
            if (w_rd_en) begin
                r_rd_fold <= w_rd_done ? '0 : r_rd_fold + FW'(1);
            end
            if (w_wr_en) begin
                if (!w_fold_end) begin
                    r_wr_fold <= r_wr_fold + FW'(1);
                end else begin
                    r_wr_fold <= '0;
                    if (w_grp_done) begin
                        r_wr_lane <= '0;
                        r_wr_grp  <= w_grp_last ? '0 : r_wr_grp + GW'(1);
                        if (w_grp_last) begin
                            r_wr_row <= (r_wr_row == ROW_LAST) ? '0
                                        : r_wr_row + RW'(1);
                        end
                    end else begin
                        r_wr_lane <= r_wr_lane + LW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        for (int k = 0; k < MMV_IN; k++) begin
            if (r_full[r_rb] && (k < int'(r_size[r_rb]))) begin
                m_axis_tdata[k*WW +: WW] =
                    r_bank[r_rb][IW'(k * CF + int'(r_rd_fold))];
            end
        end
    end

`ifdef SWU_MMV_PACK_TLAST_EN
    logic [1:0] r_last;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_last <= '0;
        end else if (w_grp_done) begin
            r_last[r_wb] <= w_grp_last && (r_wr_row == ROW_LAST);
        end
    end

    assign m_axis_tlast = r_full[r_rb] && r_last[r_rb]
                          && (r_rd_fold == FOLD_LAST);
`endif

endmodule

// File: tb/tb_swu_mmv_packer.sv
// tb_swu_mmv_packer: vector table, stall, random, reset and tail-group tests
// for swu_mmv_packer against a pixel-coordinate reference model.
module tb_swu_mmv_packer;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  sd0 = '0, sd1 = '0;
    logic        sv0 = 1'b0, sv1 = 1'b0;
    logic        sr0, sr1;
    logic [23:0] md0, md1;
    logic        mv0, mv1;
    logic        mr0 = 1'b0, mr1 = 1'b0;
    logic        tl0, tl1;

    always #5 aclk = ~aclk;

`ifndef SWU_MMV_PACK_TLAST_EN
    assign tl0 = 1'b0;
    assign tl1 = 1'b0;
`endif

    swu_mmv_packer dut0 (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(sd0), .s_axis_tvalid(sv0), .s_axis_tready(sr0),
        .m_axis_tdata(md0), .m_axis_tvalid(mv0), .m_axis_tready(mr0)
`ifdef SWU_MMV_PACK_TLAST_EN
        , .m_axis_tlast(tl0)
`endif
    );

    swu_mmv_packer #(.IFMWidth(7)) dut1 (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(sd1), .s_axis_tvalid(sv1), .s_axis_tready(sr1),
        .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tready(mr1)
`ifdef SWU_MMV_PACK_TLAST_EN
        , .m_axis_tlast(tl1)
`endif
    );

    typedef struct {
        int          dut;
        int          beat;
        logic [23:0] exp;
    } vec_t;

    vec_t        tbl [10];
    int          checks = 0;
    int          errors = 0;
    int          in_cnt [2];
    int          in_total [2];
    int          exp_b [2];
    int          vprob, rprob;
    int          cyc, first_in, last_in, first_out;
    logic [23:0] q0 [$];
    logic [23:0] q1 [$];
    bit          lq0 [$];
    bit          lq1 [$];
    bit          hold0, hold1;
    logic [23:0] hd0, hd1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int wid(input int d);
        return (d != 0) ? 7 : 6;
    endfunction

    function automatic logic [7:0] pix(input int r, input int c, input int ch);
        logic [7:0] b;
        b = {r[3:0], c[3:0]};
        if (ch == 1) b[7] = ~b[7];
        return b;
    endfunction

    // Input stream order: row-major pixels, channel innermost.
    function automatic logic [7:0] word(input int d, input int n);
        int w, m, p;
        w = wid(d);
        m = n % (w * 12);
        p = m / 2;
        return pix(p / w, p % w, m % 2);
    endfunction

    function automatic int nbeats(input int d);
        return ((wid(d) + 2) / 3) * 2 * 6;
    endfunction

    task automatic compare(input int d, input int frames);
        int w, gpr, i, n, col;
        logic [23:0] e;
        bit el;
        w = wid(d);
        gpr = (w + 2) / 3;
        n = (d != 0) ? q1.size() : q0.size();
        chk($sformatf("beat_count_dut%0d", d), n, frames * nbeats(d));
        i = 0;
        for (int fr = 0; fr < frames; fr++)
            for (int r = 0; r < 6; r++)
                for (int g = 0; g < gpr; g++)
                    for (int f = 0; f < 2; f++) begin
                        e = '0;
                        for (int k = 0; k < 3; k++) begin
                            col = g * 3 + k;
                            if (col < w) e[k*8 +: 8] = pix(r, col, f);
                        end
                        el = (r == 5) && (g == gpr - 1) && (f == 1);
                        if (i < n) begin
                            chk($sformatf("model_dut%0d_beat%0d", d, i),
                                (d != 0) ? q1[i] : q0[i], e);
`ifdef SWU_MMV_PACK_TLAST_EN
                            chk($sformatf("tlast_dut%0d_beat%0d", d, i),
                                (d != 0) ? lq1[i] : lq0[i], el);
`endif
                        end
                        i++;
                    end
    endtask

    task automatic step();
        @(negedge aclk);
        sv0 = (in_cnt[0] < in_total[0]) && ($urandom_range(99) < vprob);
        sv1 = (in_cnt[1] < in_total[1]) && ($urandom_range(99) < vprob);
        sd0 = word(0, in_cnt[0]);
        sd1 = word(1, in_cnt[1]);
        mr0 = $urandom_range(99) < rprob;
        mr1 = $urandom_range(99) < rprob;
        #1;
        if (hold0) chk("hold_dut0", {7'b0, mv0, md0}, {7'b0, 1'b1, hd0});
        if (hold1) chk("hold_dut1", {7'b0, mv1, md1}, {7'b0, 1'b1, hd1});
        hold0 = mv0 && !mr0;
        hold1 = mv1 && !mr1;
        hd0 = md0;
        hd1 = md1;
        if (sv0 && sr0) begin
            if (first_in < 0) first_in = cyc;
            last_in = cyc;
            in_cnt[0]++;
        end
        if (sv1 && sr1) in_cnt[1]++;
        if (mv0 && mr0) begin
            if (first_out < 0) first_out = cyc;
            q0.push_back(md0);
            lq0.push_back(tl0);
        end
        if (mv1 && mr1) begin
            q1.push_back(md1);
            lq1.push_back(tl1);
        end
        cyc++;
    endtask

    task automatic run(input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = (q0.size() >= exp_b[0]) && (q1.size() >= exp_b[1]);
        end
        chk("run_within_budget", {31'b0, done}, 1);
    endtask

    task automatic do_reset(input bit chk_now);
        @(negedge aclk);
        areset = 1'b1;
        sv0 = 1'b0;
        sv1 = 1'b0;
        mr0 = 1'b0;
        mr1 = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        #1;
        if (chk_now) begin
            chk("rst_tvalid0", mv0, 0);
            chk("rst_tdata0", md0, 0);
            chk("rst_tready0", sr0, 1);
            chk("rst_tvalid1", mv1, 0);
            chk("rst_tready1", sr1, 1);
        end
        in_cnt = '{0, 0};
        q0.delete();
        q1.delete();
        lq0.delete();
        lq1.delete();
        hold0 = 1'b0;
        hold1 = 1'b0;
        cyc = 0;
        first_in = -1;
        last_in = -1;
        first_out = -1;
    endtask

    initial begin
        int nb, n;
        tbl = '{
            '{0, 0,  24'h020100}, '{0, 1,  24'h828180},
            '{0, 2,  24'h050403}, '{0, 3,  24'h858483},
            '{0, 4,  24'h121110}, '{0, 23, 24'hD5D4D3},
            '{1, 4,  24'h000006}, '{1, 5,  24'h000086},
            '{1, 6,  24'h121110}, '{1, 35, 24'h0000D6}
        };
        in_total = '{0, 0};
        exp_b = '{0, 0};
        vprob = 100;
        rprob = 100;
        do_reset(1'b1);

        in_total = '{72, 84};
        exp_b = '{24, 36};
        run(400);
        chk("t1_input_no_stall", last_in - first_in, 71);
        chk("t1_first_latency", first_out - first_in, 6);
        for (int i = 0; i < 10; i++)
            chk($sformatf("vec%0d_dut%0d_beat%0d", i, tbl[i].dut, tbl[i].beat),
                (tbl[i].dut != 0) ? q1[tbl[i].beat] : q0[tbl[i].beat],
                tbl[i].exp);
        compare(0, 1);
        compare(1, 1);

        do_reset(1'b0);
        in_total = '{72, 0};
        exp_b = '{24, 0};
        repeat (15) step();
        rprob = 0;
        nb = q0.size();
        repeat (20) step();
        chk("t3_words_buffered", in_cnt[0], (nb / 2 + 2) * 6);
        chk("t3_tready_low", sr0, 0);
        chk("t3_no_out_in_stall", q0.size(), nb);
        rprob = 100;
        run(400);
        compare(0, 1);

        do_reset(1'b0);
        vprob = 50;
        rprob = 50;
        in_total = '{216, 252};
        exp_b = '{72, 108};
        run(4000);
        compare(0, 3);
        compare(1, 3);

        do_reset(1'b0);
        vprob = 100;
        rprob = 100;
        in_total = '{72, 0};
        exp_b = '{0, 0};
        n = 0;
        while (in_cnt[0] < 40 && n < 200) begin
            step();
            n++;
        end
        chk("t5_reached_40", in_cnt[0], 40);
        do_reset(1'b1);
        in_total = '{72, 0};
        exp_b = '{24, 0};
        run(400);
        compare(0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
